// File: rtl/turbo_enc_core_param_if.sv
// turbo_enc_core_param_if: block control, systematic/interleaved input streams and
// the encoded output stream of the turbo encoder core, plus an FSM debug view.
//
// Handshake rule shared by every stream here: a beat transfers on a rising clock edge
// where both valid and ready are high. Once valid is raised, the producer holds valid
// and its data stable until that transfer. Ready may rise or fall freely and does not
// need to wait for valid.
interface turbo_enc_core_param_if #(
   parameter int KW = 13
);
   logic          blk_start;
   logic [KW-1:0] blk_len;
   logic          blk_err;
   logic          sys_valid;
   logic          sys_bit;
   logic          sys_ready;
   logic          int_valid;
   logic          int_bit;
   logic          int_ready;
   logic          out_valid;
   logic          out_ready;
   logic          xk;
   logic          zk;
   logic          zk_p;
   logic          out_tail;
   logic          out_last;
   logic          busy;
   logic [2:0]    state_dbg;

   // driving side: segmentation FIFO, interleaver and rate matcher (or a testbench)
   modport master (
      output blk_start, blk_len, sys_valid, sys_bit, int_valid, int_bit, out_ready,
      input  blk_err, sys_ready, int_ready, out_valid, xk, zk, zk_p, out_tail, out_last,
             busy, state_dbg
   );

   // encoder core side
   modport slave (
      input  blk_start, blk_len, sys_valid, sys_bit, int_valid, int_bit, out_ready,
      output blk_err, sys_ready, int_ready, out_valid, xk, zk, zk_p, out_tail, out_last,
             busy, state_dbg
   );
endinterface

// File: rtl/turbo_enc_core_param.sv
// turbo_enc_core_param: dual-RSC turbo encoder core, LTE constituent code
// g0 = 1+D2+D3 (feedback), g1 = 1+D+D3, run-time block length K in [KMIN, KMAX].
// Systematic bits are stored during LOAD, then replayed in step with the externally
// interleaved stream during ENCODE; each step emits one beat {xk, zk, zk_p}.
// Optional trellis termination is built only when the macro TENC_TAIL_EN is defined:
// TAIL_RUN flushes both encoders and TAIL_OUT emits 4 tail beats. Without it the
// block ends on data beat K-1 and out_tail is tied low.
module turbo_enc_core_param #(
   parameter int KMAX = 6144,
   parameter int KMIN = 40,
   parameter int KW   = 13
) (
   input logic                   clock,
   input logic                   reset,
   turbo_enc_core_param_if.slave bus
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_ENCODE   = 3'd2;
`ifdef TENC_TAIL_EN
   localparam logic [2:0] ST_TAIL_RUN = 3'd3;
   localparam logic [2:0] ST_TAIL_OUT = 3'd4;
`endif

   logic [2:0]    state;
   logic [KW-1:0] blk_k;      // latched block length
   logic [KW-1:0] cnt;        // bit index within the block, 0..K-1
   logic [KW-1:0] last_idx;
   logic          buf_mem [KMAX];

   // encoder shift registers, bit 0 is the newest (s0), bit 2 the oldest (s2)
   logic [2:0]    s1;
   logic [2:0]    s2;

   // output beat register
   logic          out_valid_q;
   logic          xk_q;
   logic          zk_q;
   logic          zkp_q;
   logic          out_last_q;
   logic          blk_err_q;

   logic          len_ok;
   logic          start_ok;
   logic          out_free;
   logic          enc_open;
   logic          step;
   logic          step_last;
   logic          load_wr;
   logic          c_bit;
   logic          fb1;
   logic          z1;
   logic          fb2;
   logic          z2;

`ifdef TENC_TAIL_EN
   logic [2:0]    tcnt;       // TAIL_RUN cycle, 0..5
   logic [2:0]    bcnt;       // tail beats loaded, 0..4
   logic [11:0]   tail_sr;    // x_K, z_K, x_K+1, ... z'_K+2, oldest at the top
   logic [2:0]    ts;
   logic          tx;
   logic          tz;
   logic          tail_load;
   logic          out_tail_q;
`else
   logic          enc_done;   // all K steps taken, waiting for the last beat to leave
`endif

   assign last_idx  = blk_k - 1'b1;
   assign len_ok    = (bus.blk_len >= KW'(KMIN)) && (bus.blk_len <= KW'(KMAX));
   assign start_ok  = bus.blk_start && (state == ST_IDLE) && len_ok;
   assign out_free  = ~out_valid_q | bus.out_ready;
   assign load_wr   = (state == ST_LOAD) && bus.sys_valid;
`ifdef TENC_TAIL_EN
   assign enc_open  = (state == ST_ENCODE);
`else
   assign enc_open  = (state == ST_ENCODE) && !enc_done;
`endif
   assign step      = enc_open && out_free && bus.int_valid;
   assign step_last = (cnt == last_idx);

   // one RSC step on each constituent encoder
   assign c_bit = buf_mem[cnt];
   assign fb1   = c_bit ^ s1[1] ^ s1[2];
   assign z1    = fb1 ^ s1[0] ^ s1[2];
   assign fb2   = bus.int_bit ^ s2[1] ^ s2[2];
   assign z2    = fb2 ^ s2[0] ^ s2[2];

`ifdef TENC_TAIL_EN
   // tail step: input chosen as s1^s2 so the feedback is zero
   assign ts        = (tcnt < 3'd3) ? s1 : s2;
   assign tx        = ts[1] ^ ts[2];
   assign tz        = ts[0] ^ ts[2];
   assign tail_load = (state == ST_TAIL_OUT) && out_free && (bcnt != 3'd4);
   assign bus.out_tail = out_tail_q;
`else
   assign bus.out_tail = 1'b0;
`endif

   assign bus.sys_ready = (state == ST_LOAD);
   assign bus.int_ready = enc_open && out_free;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.xk        = xk_q;
   assign bus.zk        = zk_q;
   assign bus.zk_p      = zkp_q;
   assign bus.out_last  = out_last_q;
   assign bus.blk_err   = blk_err_q;
   assign bus.state_dbg = state;

   // systematic buffer write port; contents need no reset, pointers do
   always_ff @(posedge clock) begin
      if (load_wr) begin
         buf_mem[cnt] <= bus.sys_bit;
      end
   end

   // block sequencing, bit counter and encoder state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         blk_k    <= '0;
         cnt      <= '0;
         s1       <= 3'b000;
         s2       <= 3'b000;
`ifdef TENC_TAIL_EN
         tcnt     <= 3'd0;
         bcnt     <= 3'd0;
         tail_sr  <= 12'h000;
`else
         enc_done <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  blk_k <= bus.blk_len;
                  cnt   <= '0;
                  s1    <= 3'b000;
                  s2    <= 3'b000;
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (load_wr) begin
                  if (step_last) begin
                     cnt   <= '0;
                     state <= ST_ENCODE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_ENCODE: begin
               if (step) begin
                  s1 <= {s1[1:0], fb1};
                  s2 <= {s2[1:0], fb2};
                  if (step_last) begin
                     cnt <= '0;
`ifdef TENC_TAIL_EN
                     tcnt  <= 3'd0;
                     state <= ST_TAIL_RUN;
`else
                     enc_done <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`ifndef TENC_TAIL_EN
               else if (enc_done && bus.out_ready) begin
                  enc_done <= 1'b0;
                  state    <= ST_IDLE;
               end
`endif
            end
`ifdef TENC_TAIL_EN
            ST_TAIL_RUN: begin
               tail_sr <= {tail_sr[9:0], tx, tz};
               if (tcnt < 3'd3) begin
                  s1 <= {s1[1:0], 1'b0};
               end else begin
                  s2 <= {s2[1:0], 1'b0};
               end
               if (tcnt == 3'd5) begin
                  bcnt  <= 3'd0;
                  state <= ST_TAIL_OUT;
               end else begin
                  tcnt <= tcnt + 3'd1;
               end
            end
            ST_TAIL_OUT: begin
               if (tail_load) begin
                  tail_sr <= {tail_sr[8:0], 3'b000};
                  bcnt    <= bcnt + 3'd1;
               end else if ((bcnt == 3'd4) && bus.out_ready) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // output beat register: load on a data step or tail beat, clear on acceptance
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         xk_q        <= 1'b0;
         zk_q        <= 1'b0;
         zkp_q       <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef TENC_TAIL_EN
         out_tail_q  <= 1'b0;
`endif
      end else if (step) begin
         out_valid_q <= 1'b1;
         xk_q        <= c_bit;
         zk_q        <= z1;
         zkp_q       <= z2;
`ifdef TENC_TAIL_EN
         out_last_q  <= 1'b0;
         out_tail_q  <= 1'b0;
`else
         out_last_q  <= step_last;
`endif
      end
`ifdef TENC_TAIL_EN
      else if (tail_load) begin
         out_valid_q <= 1'b1;
         xk_q        <= tail_sr[11];
         zk_q        <= tail_sr[10];
         zkp_q       <= tail_sr[9];
         out_last_q  <= (bcnt == 3'd3);
         out_tail_q  <= 1'b1;
      end
`endif
      else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef TENC_TAIL_EN
         out_tail_q  <= 1'b0;
`endif
      end
   end

   // error pulse: illegal length, or a start request while a block is in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blk_err_q <= 1'b0;
      end else begin
         blk_err_q <= bus.blk_start && !start_ok;
      end
   end

endmodule

// File: tb/tb_turbo_enc_core_param.sv
// tb_turbo_enc_core_param: directed bench for turbo_enc_core_param.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected beats come from a bit-level model of the two RSC
// encoders fed from the same stimulus arrays; a few beats are also checked
// against hand-computed constants. Honours TENC_TAIL_EN like the design.
module tb_turbo_enc_core_param;
   localparam int KMAX = 6144;
   localparam int KMIN = 40;
   localparam int KW   = 13;
   localparam int W    = 5;   // {tail, last, xk, zk, zk_p}

   logic clock = 1'b0;
   logic reset;

   turbo_enc_core_param_if #(.KW(KW)) bus ();

   turbo_enc_core_param #(.KMAX(KMAX), .KMIN(KMIN), .KW(KW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int           vectors = 0;
   int           miscompares = 0;
   logic [W-1:0] exp_q[$];
   logic         sys_mem [KMAX];
   logic         int_mem [KMAX];
   logic [W-1:0] cap [64];
   int           beat_cnt = 0;

   // clock / reset
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      vectors++;
      assert (obs === expd) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
      end
   endtask

   // scoreboard: every accepted beat is compared against the expected queue
   always @(negedge clock) begin
      logic [W-1:0] got;
      logic [W-1:0] e;
      if (!reset && bus.out_valid && bus.out_ready) begin
         got = {bus.out_tail, bus.out_last, bus.xk, bus.zk, bus.zk_p};
         if (beat_cnt < 64) cap[beat_cnt] = got;
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL extra_beat observed=%0h expected=none", got);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("beat%0d", beat_cnt), 32'(got), 32'(e));
         end
         beat_cnt++;
      end
      if (!reset && bus.out_valid && !bus.out_ready)
         check("int_ready_bp", 32'(bus.int_ready), 0);
   end

   // reference model of the two constituent encoders
   task automatic push_expected(input int k);
      logic a0, a1, a2, b0, b1, b2, f, za, zb, lst;
`ifdef TENC_TAIL_EN
      logic t [12];
`endif
      a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
      b0 = 1'b0; b1 = 1'b0; b2 = 1'b0;
      for (int i = 0; i < k; i++) begin
         f  = sys_mem[i] ^ a1 ^ a2;
         za = f ^ a0 ^ a2;
         a2 = a1; a1 = a0; a0 = f;
         f  = int_mem[i] ^ b1 ^ b2;
         zb = f ^ b0 ^ b2;
         b2 = b1; b1 = b0; b0 = f;
`ifdef TENC_TAIL_EN
         lst = 1'b0;
`else
         lst = (i == k - 1);
`endif
         exp_q.push_back({1'b0, lst, sys_mem[i], za, zb});
      end
`ifdef TENC_TAIL_EN
      for (int j = 0; j < 3; j++) begin
         t[2*j] = a1 ^ a2; t[2*j+1] = a0 ^ a2;
         a2 = a1; a1 = a0; a0 = 1'b0;
      end
      for (int j = 0; j < 3; j++) begin
         t[6+2*j] = b1 ^ b2; t[7+2*j] = b0 ^ b2;
         b2 = b1; b1 = b0; b0 = 1'b0;
      end
      for (int j = 0; j < 4; j++)
         exp_q.push_back({1'b1, (j == 3), t[3*j], t[3*j+1], t[3*j+2]});
`endif
   endtask

   // driver: all inputs idle
   task automatic drive_idle();
      bus.blk_start = 1'b0;
      bus.blk_len   = '0;
      bus.sys_valid = 1'b0;
      bus.sys_bit   = 1'b0;
      bus.int_valid = 1'b0;
      bus.int_bit   = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   // driver: start pulse with an illegal length, expect a lone blk_err pulse
   task automatic bad_start(input int len);
      @(posedge clock); #1;
      bus.blk_start = 1'b1;
      bus.blk_len   = KW'(len);
      @(posedge clock); #1;
      bus.blk_start = 1'b0;
      @(negedge clock);
      check($sformatf("err_pulse_%0d", len), 32'(bus.blk_err), 1);
      check($sformatf("err_busy_%0d", len), 32'(bus.busy), 0);
      check($sformatf("err_sysrdy_%0d", len), 32'(bus.sys_ready), 0);
      @(negedge clock);
      check($sformatf("err_clear_%0d", len), 32'(bus.blk_err), 0);
   endtask

   // driver: one full block; rmode randomises out_ready, gaps randomises int_valid,
   // poke issues a second blk_start during LOAD, abort_at >= 0 resets mid-ENCODE
   task automatic run_block(input int k, input bit rmode, input bit gaps,
                            input bit poke, input int abort_at);
      int i;
      int cyc;
      logic acc;
      beat_cnt = 0;
      push_expected(k);
      @(posedge clock); #1;
      bus.blk_start = 1'b1;
      bus.blk_len   = KW'(k);
      @(posedge clock); #1;
      bus.blk_start = 1'b0;
      // LOAD
      i = 0; cyc = 0;
      while (i < k && cyc < k + 50) begin
         bus.sys_valid = 1'b1;
         bus.sys_bit   = sys_mem[i];
         bus.blk_start = poke && (cyc == 2);
         @(negedge clock);
         if (cyc == 0) check("busy_up", 32'(bus.busy), 1);
         if (poke && cyc == 3) check("busy_blk_err", 32'(bus.blk_err), 1);
         acc = bus.sys_ready;
         @(posedge clock); #1;
         if (acc) i++;
         cyc++;
      end
      bus.sys_valid = 1'b0;
      bus.blk_start = 1'b0;
      check("load_done", i, k);
      // ENCODE
      i = 0; cyc = 0;
      while (i < k && cyc < 8 * k + 100) begin
         if (abort_at >= 0 && i == abort_at) begin
            reset = 1'b1;
            bus.int_valid = 1'b0;
            @(negedge clock);
            check("abort_outputs", 32'({bus.out_valid, bus.xk, bus.zk, bus.zk_p, bus.out_tail,
                                        bus.out_last, bus.busy, bus.sys_ready, bus.int_ready,
                                        bus.blk_err}), 0);
            check("abort_state", 32'(bus.state_dbg), 0);
            exp_q.delete();
            @(posedge clock); #1;
            reset = 1'b0;
            bus.out_ready = 1'b1;
            return;
         end
         bus.int_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.int_bit   = int_mem[i];
         bus.out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clock);
         acc = bus.int_ready && bus.int_valid;
         @(posedge clock); #1;
         if (acc) i++;
         cyc++;
      end
      bus.int_valid = 1'b0;
      check("encode_done", i, k);
      // drain remaining beats
      cyc = 0;
      while ((exp_q.size() != 0 || bus.busy) && cyc < 500) begin
         bus.out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clock); #1;
         cyc++;
      end
      bus.out_ready = 1'b1;
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", 32'(bus.busy), 0);
`ifdef TENC_TAIL_EN
      check("beat_count", beat_cnt, k + 4);
`else
      check("beat_count", beat_cnt, k);
`endif
   endtask

   initial begin
      logic [2:0] imp_exp [5];
      imp_exp = '{3'b111, 3'b011, 3'b011, 3'b011, 3'b000};

      // reset state
      reset = 1'b1;
      drive_idle();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outputs", 32'({bus.out_valid, bus.xk, bus.zk, bus.zk_p, bus.out_tail,
                                  bus.out_last, bus.busy, bus.sys_ready, bus.int_ready,
                                  bus.blk_err}), 0);
      check("reset_state", 32'(bus.state_dbg), 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // illegal lengths just outside both bounds
      bad_start(KMIN - 1);
      bad_start(KMAX + 1);

      // K=40 all-zero block, second start while busy
      for (int i = 0; i < KMAX; i++) begin sys_mem[i] = 1'b0; int_mem[i] = 1'b0; end
      run_block(40, 1'b0, 1'b0, 1'b1, -1);
`ifdef TENC_TAIL_EN
      check("zero_b39_last", 32'(cap[39][3]), 0);
      check("zero_b40_tail", 32'(cap[40][4]), 1);
      check("zero_b42_last", 32'(cap[42][3]), 0);
      check("zero_b43_last", 32'(cap[43][3]), 1);
      check("zero_b43_tail", 32'(cap[43][4]), 1);
`else
      check("zero_b39_last", 32'(cap[39][3]), 1);
      check("zero_b39_tail", 32'(cap[39][4]), 0);
      check("zero_b38_last", 32'(cap[38][3]), 0);
`endif

      // K=40 impulse at k=0 on both streams
      sys_mem[0] = 1'b1;
      int_mem[0] = 1'b1;
      run_block(40, 1'b0, 1'b0, 1'b0, -1);
      for (int i = 0; i < 5; i++)
         check($sformatf("impulse_b%0d", i), 32'(cap[i][2:0]), 32'(imp_exp[i]));

      // K=KMAX random data with random backpressure and input gaps
      for (int i = 0; i < KMAX; i++) begin
         sys_mem[i] = 1'($urandom_range(0, 1));
         int_mem[i] = 1'($urandom_range(0, 1));
      end
      run_block(KMAX, 1'b1, 1'b1, 1'b0, -1);

      // reset mid-ENCODE, then a fresh K=40 random block
      run_block(200, 1'b1, 1'b1, 1'b0, 100);
      for (int i = 0; i < 40; i++) begin
         sys_mem[i] = 1'($urandom_range(0, 1));
         int_mem[i] = 1'($urandom_range(0, 1));
      end
      run_block(40, 1'b1, 1'b0, 1'b0, -1);

      repeat (2) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
